// File: rtl/barrel_shift_arb.sv
// barrel_shift_arb: round-robin arbiter sharing one 8-bit barrel shifter
// between NREQ requesters. One command accepted per cycle; the shifted
// result is registered and returned with the issuing requester's ID.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   req_valid_i  per-requester command valid
//   req_ready_o  per-requester accept (one-hot or zero, combinational)
//   req_data_i   packed operands, requester i at [i*N +: N]
//   req_shift_i  packed shift amounts, requester i at [i*3 +: 3]
//   req_op_i     packed op codes: 0 SRL, 1 SRA, 2 SLL, 3 ROR, 4 ROL, 5..7 illegal
//   rsp_valid_o  response valid
//   rsp_ready_i  response consumer ready
//   rsp_data_o   shifted result
//   rsp_id_o     requester index of the response
//   rsp_err_o    illegal op code flag
module barrel_shift_arb #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic [NREQ*N-1:0]   req_data_i,
    input  logic [NREQ*3-1:0]   req_shift_i,
    input  logic [NREQ*3-1:0]   req_op_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [N-1:0]        rsp_data_o,
    output logic [IDW-1:0]      rsp_id_o,
    output logic                rsp_err_o
);

    localparam int unsigned SHW = 3;

    // One barrel-shifter stage by a fixed power-of-two amount.
    function automatic logic [N-1:0] shift_stage(input logic [N-1:0] d,
                                                 input logic [2:0]   op,
                                                 input int unsigned  amt);
        logic [N-1:0] r;
        case (op)
            3'd0:    r = d >> amt;
            3'd1:    r = N'($signed(d) >>> amt);
            3'd2:    r = d << amt;
            3'd3:    r = (d >> amt) | (d << (N - amt));
            3'd4:    r = (d << amt) | (d >> (N - amt));
            default: r = d;  // illegal ops pass the operand through
        endcase
        return r;
    endfunction

    // Log shifter: stages of 1, 2 and 4 selected by the shift-amount bits.
    function automatic logic [N-1:0] barrel_shift(input logic [N-1:0]   d,
                                                  input logic [SHW-1:0] sh,
                                                  input logic [2:0]     op);
        logic [N-1:0] v;
        v = d;
        for (int unsigned k = 0; k < SHW; k++) begin
            if (sh[k]) v = shift_stage(v, op, 32'd1 << k);
        end
        return v;
    endfunction

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           rsp_valid_q;
    logic [N-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_err_q, rsp_err_d;

    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic           slot_free;
    logic           accept;
    logic [N-1:0]   sel_data;
    logic [SHW-1:0] sel_shift;
    logic [2:0]     sel_op;

    // Round-robin search starting at rr_ptr, wrapping at NREQ-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + i) % NREQ;
            if (!found && req_valid_i[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // The output register is the only storage: free when empty or draining.
    assign slot_free = !rsp_valid_q || rsp_ready_i;
    assign accept    = found && slot_free && !rst;

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[gnt_idx] = 1'b1;
    end

    // Datapath mux from the granted requester into the shared shifter.
    always_comb begin
        sel_data   = req_data_i[32'(gnt_idx)*N +: N];
        sel_shift  = req_shift_i[32'(gnt_idx)*SHW +: SHW];
        sel_op     = req_op_i[32'(gnt_idx)*3 +: 3];
        rsp_data_d = barrel_shift(sel_data, sel_shift, sel_op);
        rsp_err_d  = (sel_op >= 3'd5);
        rr_ptr_d   = IDW'((32'(gnt_idx) + 32'd1) % NREQ);
    end

    // Response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= gnt_idx;
            rsp_err_q   <= rsp_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Directed testbench for barrel_shift_arb (N=8, NREQ=4).
module tb_barrel_shift_arb;

    localparam int unsigned N    = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ*3-1:0] req_shift;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;

    int n_vec;
    int n_err;

    barrel_shift_arb #(.N(N), .NREQ(NREQ)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_shift_i (req_shift),
        .req_op_i    (req_op),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .rsp_err_o   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [7:0] d, input logic [2:0] sh, input logic [2:0] op);
        req_data[i*N +: N] = d;
        req_shift[i*3 +: 3] = sh;
        req_op[i*3 +: 3]    = op;
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] d, input logic [1:0] id, input logic err);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".data"},  32'(rsp_data),  32'(d));
        check({tag, ".id"},    32'(rsp_id),    32'(id));
        check({tag, ".err"},   32'(rsp_err),   32'(err));
    endtask

    logic [7:0] sv_d  [5] = '{8'hB4, 8'hB4, 8'h81, 8'h81, 8'h81};
    logic [2:0] sv_op [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] sv_sh [5] = '{3'd3, 3'd2, 3'd1, 3'd1, 3'd1};
    logic [7:0] sv_ex [5] = '{8'h16, 8'hED, 8'h02, 8'hC0, 8'h03};
    logic [1:0] rr_ex [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] rr2_ex[3] = '{2'd3, 2'd1, 2'd3};

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        req_shift = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        // Reset: no grant while rst is high, outputs cleared.
        #1;
        check("rst.ready", 32'(req_ready), 32'h0);
        tick();
        check("rst.ready2", 32'(req_ready), 32'h0);
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.data",  32'(rsp_data),  32'h00);
        check("rst.id",    32'(rsp_id),    32'd0);
        check("rst.err",   32'(rsp_err),   32'd0);
        rst = 1'b0;
        #1;
        check("rst.first_gnt", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();
        check("idle.valid", 32'(rsp_valid), 32'd0);

        // Single requester 1, one command per cycle.
        for (int k = 0; k < 5; k++) begin
            set_cmd(1, sv_d[k], sv_sh[k], sv_op[k]);
            req_valid = 4'b0010;
            #1;
            check($sformatf("single%0d.ready", k), 32'(req_ready), 32'b0010);
            tick();
            check_rsp($sformatf("single%0d", k), sv_ex[k], 2'd1, 1'b0);
        end
        req_valid = '0;
        tick();
        check("drain.valid", 32'(rsp_valid), 32'd0);

        // Restart pointer at 0 for contention.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_cmd(i, 8'(i), 3'd0, 3'd0);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_rsp($sformatf("rr%0d", k), 8'(rr_ex[k]), rr_ex[k], 1'b0);
        end
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_rsp($sformatf("rr2_%0d", k), 8'(rr2_ex[k]), rr2_ex[k], 1'b0);
        end

        // Backpressure: response from requester 3 held for 5 cycles.
        rsp_ready = 1'b0;
        set_cmd(0, 8'h0F, 3'd4, 3'd2);
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
            tick();
            check_rsp($sformatf("bp%0d", k), 8'h03, 2'd3, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("bp.nobubble", 8'hF0, 2'd0, 1'b0);

        // Illegal op from requester 2; next search starts at 3.
        set_cmd(2, 8'h5A, 3'd2, 3'd6);
        req_valid = 4'b0100;
        tick();
        check_rsp("illegal", 8'h5A, 2'd2, 1'b1);
        set_cmd(0, 8'hA5, 3'd0, 3'd3);
        req_valid = 4'b0101;
        #1;
        check("illegal.next_gnt", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("shift0", 8'hA5, 2'd0, 1'b0);

        // Reset mid-stream with a stalled response.
        rsp_ready = 1'b0;
        req_valid = '0;
        tick();
        check("mid.held_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mid.valid", 32'(rsp_valid), 32'd0);
        check("mid.data",  32'(rsp_data),  32'h00);
        rst = 1'b0;
        req_valid = 4'b1100;
        #1;
        check("mid.gnt", 32'(req_ready), 32'b0100);
        tick();
        check("mid.rsp_id", 32'(rsp_id), 32'd2);
        check("mid.rsp_valid", 32'(rsp_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
